// File: rtl/sprite_line_fill_if.sv
// Handshake and bus bundle between the sprite evaluator / tile table / line buffer
// and the sprite line-fill engine.
interface sprite_line_fill_if;
    logic        start;
    logic        abort;
    logic [8:0]  sprite_x;
    logic        spr_hflip;
    logic [2:0]  spr_size_x;
    logic        spr_table;
    logic [3:0]  spr_tile_x;
    logic [3:0]  spr_tile_y_total;
    logic [2:0]  spr_tile_y_offset;
    logic [3:0]  palette;
    logic        busy;
    logic        done;
    logic        load;
    logic        hFlip;
    logic [2:0]  size_x;
    logic        tile_table;
    logic [3:0]  tile_x;
    logic [3:0]  tile_y_total;
    logic [2:0]  tile_y_offset;
    logic [3:0]  current_tile;
    logic [31:0] tile_data;
    logic        lb_we;
    logic [8:0]  lb_addr;
    logic [7:0]  lb_data;

    modport master (
        output start, abort, sprite_x, spr_hflip, spr_size_x, spr_table,
               spr_tile_x, spr_tile_y_total, spr_tile_y_offset, palette, tile_data,
        input  busy, done, load, hFlip, size_x, tile_table, tile_x, tile_y_total,
               tile_y_offset, current_tile, lb_we, lb_addr, lb_data
    );

    modport slave (
        input  start, abort, sprite_x, spr_hflip, spr_size_x, spr_table,
               spr_tile_x, spr_tile_y_total, spr_tile_y_offset, palette, tile_data,
        output busy, done, load, hFlip, size_x, tile_table, tile_x, tile_y_total,
               tile_y_offset, current_tile, lb_we, lb_addr, lb_data
    );
endinterface

// File: rtl/sprite_line_fill.sv
// Sprite line-fill engine: fetches each tile word of one sprite row and writes its
// opaque pixels, tagged with the sprite palette, into the scanline buffer.
module sprite_line_fill #(
    parameter int LINE_W = 320
) (
    input logic               clk,
    input logic               rst,
    sprite_line_fill_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_FETCH, S_CAPTURE, S_DRAW, S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [8:0]  r_sprite_x;
    logic        r_hflip;
    logic [2:0]  r_size_x;
    logic        r_table;
    logic [3:0]  r_tile_x;
    logic [3:0]  r_tile_y_total;
    logic [2:0]  r_tile_y_offset;
    logic [3:0]  r_palette;

    logic [3:0]  r_k;
    logic [2:0]  r_j;
    logic [31:0] r_pix;
    logic [11:0] r_x;

    logic [3:0]  w_pixel;
    logic        w_last_px;
    logic        w_last_tile;

    function automatic logic on_line(input logic [11:0] x);
        return x < 12'(LINE_W);
    endfunction

    assign w_pixel     = r_pix[3:0];
    assign w_last_px   = (r_j == 3'd7);
    assign w_last_tile = (r_k == {1'b0, r_size_x});

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (bus.abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (bus.start) w_next = S_LOAD;
                S_LOAD:    w_next = S_FETCH;
                S_FETCH:   w_next = S_CAPTURE;
                S_CAPTURE: w_next = S_DRAW;
                S_DRAW:    if (w_last_px) w_next = w_last_tile ? S_DONE : S_FETCH;
                S_DONE:    w_next = S_IDLE;
                default:   w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.busy    = (r_state == S_LOAD) || (r_state == S_FETCH) ||
                      (r_state == S_CAPTURE) || (r_state == S_DRAW);
        bus.done    = (r_state == S_DONE);
        bus.load    = (r_state == S_LOAD);
        bus.lb_we   = 1'b0;
        bus.lb_addr = 9'd0;
        bus.lb_data = 8'd0;
        if (r_state == S_DRAW) begin
            // Transparent nibbles and off-line pixels never reach the buffer.
            bus.lb_we   = (w_pixel != 4'd0) && on_line(r_x) && !bus.abort;
            bus.lb_addr = r_x[8:0];
            bus.lb_data = {r_palette, w_pixel};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sprite_x      <= '0;
            r_hflip         <= 1'b0;
            r_size_x        <= '0;
            r_table         <= 1'b0;
            r_tile_x        <= '0;
            r_tile_y_total  <= '0;
            r_tile_y_offset <= '0;
            r_palette       <= '0;
            r_k             <= '0;
            r_j             <= '0;
            r_pix           <= '0;
            r_x             <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        r_sprite_x      <= bus.sprite_x;
                        r_hflip         <= bus.spr_hflip;
                        r_size_x        <= bus.spr_size_x;
                        r_table         <= bus.spr_table;
                        r_tile_x        <= bus.spr_tile_x;
                        r_tile_y_total  <= bus.spr_tile_y_total;
                        r_tile_y_offset <= bus.spr_tile_y_offset;
                        r_palette       <= bus.palette;
                        r_k             <= '0;
                        r_x             <= {3'b000, bus.sprite_x};
                    end
                end
                S_CAPTURE: begin
                    r_pix <= bus.tile_data;
                    r_j   <= '0;
                end
                S_DRAW: begin
                    // x runs contiguously across tiles, so it always equals sprite_x + 8k + j.
                    r_pix <= {4'd0, r_pix[31:4]};
                    r_j   <= r_j + 3'd1;
                    r_x   <= r_x + 12'd1;
                    if (w_last_px && !w_last_tile) r_k <= r_k + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.hFlip         = r_hflip;
    assign bus.size_x        = r_size_x;
    assign bus.tile_table    = r_table;
    assign bus.tile_x        = r_tile_x;
    assign bus.tile_y_total  = r_tile_y_total;
    assign bus.tile_y_offset = r_tile_y_offset;
    assign bus.current_tile  = r_k;
endmodule

// File: tb/tb_sprite_line_fill.sv
// Directed bench for sprite_line_fill: single tile, transparency, clipping,
// flip forwarding with ignored start, abort with restart, and mid-fill reset.
module tb_sprite_line_fill;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sprite_line_fill_if bus ();

    sprite_line_fill #(.LINE_W(320)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc;
    int start_at2, abort_at, rst_at;
    int          wr_cyc[$];
    logic [8:0]  wr_addr[$];
    logic [7:0]  wr_data[$];
    int done_cnt, done_cyc, load_cnt;
    logic        busy_h[64];
    logic [3:0]  ct_h[64];
    logic        hf_h[64];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_wr(input string tag, input int idx, input int ec, input int ea, input int ed);
        if (idx < wr_cyc.size()) begin
            check({tag, "_cyc"},  wr_cyc[idx],  ec);
            check({tag, "_addr"}, wr_addr[idx], ea);
            check({tag, "_data"}, wr_data[idx], ed);
        end else begin
            check({tag, "_missing"}, wr_cyc.size(), idx + 1);
        end
    endtask

    // One clock: inputs change 1 time unit after the edge, outputs sampled 3 after.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        bus.start = (cyc == start_at2);
        bus.abort = (cyc == abort_at);
        rst       = (cyc != rst_at);
        #2;
        if (cyc < 64) begin
            busy_h[cyc] = bus.busy;
            ct_h[cyc]   = bus.current_tile;
            hf_h[cyc]   = bus.hFlip;
        end
        if (bus.lb_we) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(bus.lb_addr);
            wr_data.push_back(bus.lb_data);
        end
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.load) load_cnt++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic launch(input logic [8:0] sx, input logic [2:0] sz, input logic [3:0] pal,
                          input logic fl, input logic [31:0] td,
                          input int s2, input int ab, input int rs);
        @(posedge clk);
        #1;
        bus.sprite_x          = sx;
        bus.spr_size_x        = sz;
        bus.palette           = pal;
        bus.spr_hflip         = fl;
        bus.tile_data         = td;
        bus.spr_table         = 1'b1;
        bus.spr_tile_x        = 4'd3;
        bus.spr_tile_y_total  = 4'd9;
        bus.spr_tile_y_offset = 3'd5;
        bus.start             = 1'b1;
        start_at2 = s2;
        abort_at  = ab;
        rst_at    = rs;
        cyc       = 0;
        wr_cyc.delete();
        wr_addr.delete();
        wr_data.delete();
        done_cnt = 0;
        done_cyc = -1;
        load_cnt = 0;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.sprite_x = '0;
        bus.spr_hflip = 1'b0;
        bus.spr_size_x = '0;
        bus.spr_table = 1'b0;
        bus.spr_tile_x = '0;
        bus.spr_tile_y_total = '0;
        bus.spr_tile_y_offset = '0;
        bus.palette = '0;
        bus.tile_data = '0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check("rst_busy",  bus.busy,         0);
        check("rst_done",  bus.done,         0);
        check("rst_load",  bus.load,         0);
        check("rst_we",    bus.lb_we,        0);
        check("rst_ct",    bus.current_tile, 0);
        check("rst_addr",  bus.lb_addr,      0);
        check("rst_data",  bus.lb_data,      0);
        check("rst_tilex", bus.tile_x,       0);
        rst = 1'b1;

        // Single tile
        launch(9'd10, 3'd0, 4'd5, 1'b0, 32'h87654321, -1, -1, -1);
        run(14);
        check("t1_load_cnt", load_cnt,  1);
        check("t1_busy1",    busy_h[1], 1);
        check("t1_ct2",      ct_h[2],   0);
        check("t1_nwr",      wr_cyc.size(), 8);
        for (int i = 0; i < 8; i++) check_wr("t1_wr", i, 4 + i, 10 + i, 8'h51 + i);
        check("t1_done_cyc", done_cyc,   12);
        check("t1_done_cnt", done_cnt,   1);
        check("t1_busy11",   busy_h[11], 1);
        check("t1_busy12",   busy_h[12], 0);
        check("t1_tbl",      bus.tile_table,    1);
        check("t1_tilex",    bus.tile_x,        3);
        check("t1_tiley",    bus.tile_y_total,  9);
        check("t1_tileoff",  bus.tile_y_offset, 5);

        // Transparency
        launch(9'd0, 3'd0, 4'd3, 1'b0, 32'h0F00000A, -1, -1, -1);
        run(14);
        check("t2_nwr", wr_cyc.size(), 2);
        check_wr("t2_wr0", 0, 4, 0, 8'h3A);
        check_wr("t2_wr1", 1, 10, 6, 8'h3F);
        check("t2_done_cyc", done_cyc, 12);

        // Clipping at the right edge, two tiles
        launch(9'd316, 3'd1, 4'd2, 1'b0, 32'h11111111, -1, -1, -1);
        run(24);
        check("t3_nwr", wr_cyc.size(), 4);
        for (int i = 0; i < 4; i++) check_wr("t3_wr", i, 4 + i, 316 + i, 8'h21);
        check("t3_ct11",     ct_h[11],   0);
        check("t3_ct12",     ct_h[12],   1);
        check("t3_ct21",     ct_h[21],   1);
        check("t3_done_cyc", done_cyc,   22);
        check("t3_busy21",   busy_h[21], 1);
        check("t3_size",     bus.size_x, 1);

        // Flip forwarded only; start while busy ignored
        launch(9'd100, 3'd0, 4'd1, 1'b1, 32'h00000021, 5, -1, -1);
        run(14);
        check("t4_hflip6",   hf_h[6],  1);
        check("t4_nwr",      wr_cyc.size(), 2);
        check_wr("t4_wr0", 0, 4, 100, 8'h11);
        check_wr("t4_wr1", 1, 5, 101, 8'h12);
        check("t4_load_cnt", load_cnt, 1);
        check("t4_done_cnt", done_cnt, 1);
        check("t4_done_cyc", done_cyc, 12);

        // Abort in cycle 6, restart in cycle 8
        launch(9'd20, 3'd1, 4'd4, 1'b0, 32'h11111111, 8, 6, -1);
        run(32);
        check("t5_nwr", wr_cyc.size(), 18);
        check_wr("t5_wr0",  0,  4, 20, 8'h41);
        check_wr("t5_wr1",  1,  5, 21, 8'h41);
        check_wr("t5_wr2",  2, 12, 20, 8'h41);
        check_wr("t5_wr17", 17, 29, 35, 8'h41);
        check("t5_busy7",    busy_h[7], 0);
        check("t5_busy9",    busy_h[9], 1);
        check("t5_load_cnt", load_cnt,  2);
        check("t5_done_cnt", done_cnt,  1);
        check("t5_done_cyc", done_cyc,  30);

        // Reset during tile 1 of a four-tile fill
        launch(9'd50, 3'd3, 4'd6, 1'b0, 32'h11111111, -1, -1, 15);
        run(25);
        check("t6_nwr", wr_cyc.size(), 10);
        check_wr("t6_wr0", 0,  4, 50, 8'h61);
        check_wr("t6_wr7", 7, 11, 57, 8'h61);
        check_wr("t6_wr8", 8, 14, 58, 8'h61);
        check_wr("t6_wr9", 9, 15, 59, 8'h61);
        check("t6_busy15",   busy_h[15], 1);
        check("t6_ct15",     ct_h[15],   1);
        check("t6_busy16",   busy_h[16], 0);
        check("t6_ct16",     ct_h[16],   0);
        check("t6_busy25",   busy_h[25], 0);
        check("t6_load_cnt", load_cnt,   1);
        check("t6_done_cnt", done_cnt,   0);
        check("t6_size",     bus.size_x, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/sprite_line_fill.md
# sprite_line_fill

Sprite line-fill engine for the GPU scanline renderer. For one sprite row it drives the sprite tile table's fetch port: it loads the row's address fields, steps `current_tile` across the sprite width, and captures each 32-bit tile word (8 × 4-bit pixels). It then writes the opaque pixels, tagged with the sprite palette, into the 320-pixel line buffer. It sits between the sprite evaluator, which issues one `start` per visible sprite, and the tile table plus line buffer.

## Interface
Parameters:
- LINE_W, 320, visible pixels per line; writes at x ≥ LINE_W are suppressed.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- start  in  1  request a fill; accepted only in IDLE
- abort  in  1  end-of-line kill; returns to IDLE
- sprite_x  in  9  screen x of the sprite's left edge
- spr_hflip  in  1  horizontal flip flag
- spr_size_x  in  3  width in tiles minus 1 (1–8 tiles)
- spr_table  in  1  tile table select
- spr_tile_x  in  4  base tile column
- spr_tile_y_total  in  4  tile row
- spr_tile_y_offset  in  3  line within the tile
- palette  in  4  palette index for this sprite
- busy  out  1  high from the cycle after `start` is accepted until `done`
- done  out  1  one-cycle pulse when the fill completes
- load  out  1  tile table latch strobe
- hFlip, size_x, tile_table, tile_x, tile_y_total, tile_y_offset  out  1/3/1/4/4/3  registered copies of the `spr_*` inputs for the tile table
- current_tile  out  4  tile index within the sprite
- tile_data  in  32  tile word; leftmost screen pixel is [3:0], rightmost is [31:28]. Flip is already applied by the tile table.
- lb_we  out  1  line buffer write enable
- lb_addr  out  9  line buffer pixel address
- lb_data  out  8  {palette, pixel}

## Operation
- States: IDLE, LOAD, FETCH, CAPTURE, DRAW, DONE.
- IDLE
  - On `start`, register all `spr_*`, `sprite_x` and `palette` inputs.
  - Set tile counter k=0, then go to LOAD.
  - `start` in any other state is ignored.
- LOAD: assert `load` for exactly one cycle, then go to FETCH.
- FETCH: drive `current_tile`=k, then go to CAPTURE.
- CAPTURE: latch `tile_data` into an 8-nibble shift register, set pixel counter j=0, then go to DRAW.
- DRAW: 8 cycles, j=0..7.
  - Pixel p = nibble j.
  - x = sprite_x + 8·k + j, computed at 12 bits (no wrap).
  - `lb_we`=1 iff p≠0 and x<LINE_W.
  - `lb_addr`=x[8:0], `lb_data`={palette,p}.
  - After j=7: if k==size_x go to DONE; else k←k+1 and go to FETCH.
- DONE: `done`=1 for one cycle, `busy`=0 from this cycle, then go to IDLE.
- `current_tile` holds k from FETCH through the end of that tile's DRAW.
- The engine does no pixel reordering; flip is the tile table's job. The `hFlip` output is forwarded only.
- abort (highest priority after reset)
  - Sampled at every edge: the next state is IDLE.
  - `lb_we` is gated combinationally by !abort in the abort cycle.
  - No `done` pulse.
- Reset values: state IDLE; busy, done, load, lb_we = 0; current_tile, lb_addr, lb_data, and all registered sprite fields = 0.

## Timing
- `start` accepted at edge S. Then:
  - S+1: LOAD.
  - S+2: FETCH for tile 0.
  - S+3: CAPTURE; `tile_data` is valid here, from the one-cycle synchronous tile RAM.
  - S+4..S+11: DRAW for tile 0.
- Each tile costs 10 cycles.
- `done` is high at cycle S+2+10·(size_x+1).
- Total occupancy is 3+10·(size_x+1) cycles; the maximum, 83 cycles, is at size_x=7.
- `busy` is high S+1 through the cycle before `done`.
- A new `start` may be accepted in the cycle after `done`.
- Reset mid-fill:
  - Next cycle is IDLE with all outputs at reset values.
  - No line buffer writes occur after the reset edge.

## Test plan
- **Single tile:** start with sprite_x=10, size_x=0, palette=5, tile_data=0x87654321 → `load` at S+1, `current_tile`=0. Writes at S+4..S+11 to addresses 10..17 with data 0x51..0x58. `done` at S+12.
- **Transparency:** tile_data=0x0F00000A, sprite_x=0 → exactly two writes: addr 0 data {pal,A} and addr 6 data {pal,F}. No `lb_we` on the other six cycles.
- **Clipping:** sprite_x=316, size_x=1, all nibbles 1 → writes only to 316–319. `current_tile` steps 0 then 1. `done` at S+22. No write to an address <316.
- **Flip forward / ignore start:** spr_hflip=1 → `hFlip`=1 while busy, and `lb_data` order still follows nibble order. A `start` pulsed while busy is ignored; no second `load`.
- **Abort:** abort at S+6 → next cycle IDLE, `lb_we`=0 from S+6, no `done`. A new start at S+8 runs normally.
- **Reset:** rst=0 at S+15 of a size_x=3 fill → busy, lb_we and current_tile are 0 next cycle, and the state stays IDLE until a new `start`.
